// File: rtl/spi_dec_pkg.sv
// Shared types for the SPI link decoder: FSM state encoding, the decoded
// transaction record and the serial field widths.
package spi_dec_pkg;

    localparam int SPI_DEC_ADDR_W = 8;
    localparam int SPI_DEC_DATA_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_ADDR       = 3'd1,
        ST_WDATA      = 3'd2,
        ST_WAIT_READY = 3'd3,
        ST_RDATA      = 3'd4,
        ST_WAIT_DONE  = 3'd5
    } spi_dec_state_t;

    typedef struct packed {
        logic                      err;
        logic                      wr;
        logic [SPI_DEC_ADDR_W-1:0] addr;
        logic [SPI_DEC_DATA_W-1:0] data;
    } spi_dec_rec_t;

    // Assemble a record from its fields.
    function automatic spi_dec_rec_t make_rec(
        input logic                      err,
        input logic                      wr,
        input logic [SPI_DEC_ADDR_W-1:0] addr,
        input logic [SPI_DEC_DATA_W-1:0] data
    );
        spi_dec_rec_t r;
        r.err  = err;
        r.wr   = wr;
        r.addr = addr;
        r.data = data;
        return r;
    endfunction

endpackage

// File: rtl/spi_dec_fifo.sv
// Show-ahead synchronous FIFO of decoded records. Read and write pointers
// carry one extra wrap bit so full and empty are distinguished without a
// separate counter. A push while full is accepted only if a pop happens in
// the same cycle; otherwise the caller sees full_o and drops the record.
module spi_dec_fifo
    import spi_dec_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  spi_dec_rec_t push_rec_i,
    input  logic         pop_i,
    output spi_dec_rec_t head_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int AW = $clog2(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("spi_dec_fifo: DEPTH must be a power of 2 and at least 2");
    end

    logic [AW:0]  wr_ptr_q;
    logic [AW:0]  rd_ptr_q;
    spi_dec_rec_t mem_q [DEPTH];
    logic         wr_en;
    logic         rd_en;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign wr_en   = push_i && (!full_o || pop_i);
    assign rd_en   = pop_i && !empty_o;
    assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    // Advance pointers on accepted pushes and pops.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Storage array; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= push_rec_i;
    end

endmodule

// File: rtl/spi_link_decoder.sv
// Passive SPI memory link decoder. Snoops cs/mosi/miso/ready/op_done,
// rebuilds each transaction as an {err, wr, addr, data} record and queues it
// in spi_dec_fifo for a consumer with a valid/ready interface.
//
// Record handshake: rec_valid means the rec_* fields hold the head record;
// the record is consumed on any cycle where rec_valid && rec_ready, and the
// fields must not be sampled when rec_valid is low.
//
// Optional build macro SPI_DEC_TIMEOUT_EN: adds a watchdog that aborts a
// frame stuck in WAIT_READY or WAIT_DONE after TIMEOUT_CYC cycles.
module spi_link_decoder
    import spi_dec_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int MEM_WORDS   = 32,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cs,
    input  logic       mosi,
    input  logic       miso,
    input  logic       ready,
    input  logic       op_done,
    output logic       rec_valid,
    input  logic       rec_ready,
    output logic       rec_err,
    output logic       rec_wr,
    output logic [7:0] rec_addr,
    output logic [7:0] rec_data,
    output logic       ovf,
    input  logic       clr_ovf,
    output logic       busy,
    output logic [2:0] dbg_state
);

    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("spi_link_decoder: TIMEOUT_CYC must be at least 1");
    end

    spi_dec_state_t            state_q;
    logic [2:0]                cnt_q;
    logic                      cs_q;
    logic                      wr_q;
    logic [SPI_DEC_ADDR_W-1:0] addr_q;
    logic [SPI_DEC_DATA_W-1:0] data_q;
    logic                      ovf_q;

    logic                      cs_fall;
    logic                      cs_rise;
    logic                      addr_err;
    logic                      wd_expire;
    logic                      push;
    spi_dec_rec_t              push_rec;
    logic                      pop;
    logic                      fifo_full;
    logic                      fifo_empty;
    spi_dec_rec_t              head;

    assign cs_fall  = cs_q && !cs;
    assign cs_rise  = !cs_q && cs;
    assign addr_err = int'(addr_q) >= MEM_WORDS;

`ifdef SPI_DEC_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC) + 1;
    logic [WD_W-1:0] wdog_q;

    // Expires on the last allowed waiting cycle if the awaited pulse is absent.
    assign wd_expire = (wdog_q == WD_W'(TIMEOUT_CYC - 1)) &&
                       ((state_q == ST_WAIT_READY && !ready) ||
                        (state_q == ST_WAIT_DONE  && !op_done));

    // Count cycles spent waiting; any other state holds it at zero, so every
    // entry into a wait state starts from zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            wdog_q <= '0;
        end else if (state_q == ST_WAIT_READY || state_q == ST_WAIT_DONE) begin
            wdog_q <= wdog_q + 1'b1;
        end else begin
            wdog_q <= '0;
        end
    end
`else
    assign wd_expire = 1'b0;
`endif

    // Decide when a record is produced this cycle and what it carries.
    always_comb begin
        push     = 1'b0;
        push_rec = '0;
        case (state_q)
            ST_ADDR, ST_WDATA: begin
                if (cs_rise) begin
                    push     = 1'b1;
                    push_rec = make_rec(1'b1, wr_q, addr_q, data_q);
                end
            end
            ST_WAIT_READY: begin
                if (wd_expire) begin
                    push     = 1'b1;
                    push_rec = make_rec(1'b1, wr_q, addr_q, data_q);
                end
            end
            ST_WAIT_DONE: begin
                if (op_done) begin
                    push     = 1'b1;
                    push_rec = make_rec(addr_err, wr_q, addr_q, data_q);
                end else if (wd_expire) begin
                    push     = 1'b1;
                    push_rec = make_rec(1'b1, wr_q, addr_q, data_q);
                end
            end
            default: begin
                push     = 1'b0;
                push_rec = '0;
            end
        endcase
    end

    // Frame FSM: edge detect, serial field capture and frame termination.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            cs_q    <= 1'b1;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            cs_q <= cs;
            case (state_q)
                ST_IDLE: begin
                    if (cs_fall) begin
                        wr_q    <= mosi;
                        addr_q  <= '0;
                        data_q  <= '0;
                        cnt_q   <= '0;
                        state_q <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (cs_rise) begin
                        cnt_q   <= '0;
                        state_q <= ST_IDLE;
                    end else begin
                        addr_q[cnt_q] <= mosi;
                        cnt_q         <= cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            state_q <= wr_q ? ST_WDATA : ST_WAIT_READY;
                        end
                    end
                end
                ST_WDATA: begin
                    if (cs_rise) begin
                        cnt_q   <= '0;
                        state_q <= ST_IDLE;
                    end else begin
                        data_q[cnt_q] <= mosi;
                        cnt_q         <= cnt_q + 3'd1;
                        if (cnt_q == 3'd7) state_q <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_READY: begin
                    if (ready) begin
                        cnt_q   <= '0;
                        state_q <= ST_RDATA;
                    end else if (wd_expire) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_RDATA: begin
                    data_q[cnt_q] <= miso;
                    cnt_q         <= cnt_q + 3'd1;
                    if (cnt_q == 3'd7) state_q <= ST_WAIT_DONE;
                end
                ST_WAIT_DONE: begin
                    if (op_done || wd_expire) state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Sticky overflow: a new drop wins over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (push && fifo_full && !pop) begin
            ovf_q <= 1'b1;
        end else if (clr_ovf) begin
            ovf_q <= 1'b0;
        end
    end

    assign pop = !fifo_empty && rec_ready;

    spi_dec_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (push),
        .push_rec_i (push_rec),
        .pop_i      (pop),
        .head_o     (head),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    assign rec_valid = !fifo_empty;
    assign rec_err   = head.err;
    assign rec_wr    = head.wr;
    assign rec_addr  = head.addr;
    assign rec_data  = head.data;
    assign ovf       = ovf_q;
    assign busy      = (state_q != ST_IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_spi_link_decoder.sv
// Directed bench for spi_link_decoder. Inputs change on the falling clock
// edge, outputs are checked on the falling edge as well.
module tb_spi_link_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cs = 1'b1;
    logic       mosi = 1'b0;
    logic       miso = 1'b0;
    logic       ready = 1'b0;
    logic       op_done = 1'b0;
    logic       rec_valid;
    logic       rec_ready = 1'b0;
    logic       rec_err;
    logic       rec_wr;
    logic [7:0] rec_addr;
    logic [7:0] rec_data;
    logic       ovf;
    logic       clr_ovf = 1'b0;
    logic       busy;
    logic [2:0] dbg_state;
    logic [17:0] rec_bus;

    int total = 0;
    int bad   = 0;

    assign rec_bus = {rec_err, rec_wr, rec_addr, rec_data};

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    spi_link_decoder #(
        .DEPTH       (8),
        .MEM_WORDS   (32),
        .TIMEOUT_CYC (64)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cs        (cs),
        .mosi      (mosi),
        .miso      (miso),
        .ready     (ready),
        .op_done   (op_done),
        .rec_valid (rec_valid),
        .rec_ready (rec_ready),
        .rec_err   (rec_err),
        .rec_wr    (rec_wr),
        .rec_addr  (rec_addr),
        .rec_data  (rec_data),
        .ovf       (ovf),
        .clr_ovf   (clr_ovf),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // ---------------- driver tasks ----------------
    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1; cs = 1'b1; mosi = 1'b0; ready = 1'b0; op_done = 1'b0;
        rec_ready = 1'b0; clr_ovf = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic start_frame(input logic op);
        @(negedge clk);
        cs = 1'b0; mosi = op;
    endtask

    task automatic shift_mosi(input logic [7:0] v, input int nb);
        for (int i = 0; i < nb; i++) begin
            @(negedge clk);
            mosi = v[i];
        end
    endtask

    task automatic do_write(input logic [7:0] a, input logic [7:0] d,
                            input int gap, input logic pop_at_done);
        start_frame(1'b1);
        shift_mosi(a, 8);
        shift_mosi(d, 8);
        @(negedge clk);
        cs = 1'b1; mosi = 1'b0;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        op_done = 1'b1;
        if (pop_at_done) rec_ready = 1'b1;
        @(negedge clk);
        op_done = 1'b0; rec_ready = 1'b0;
    endtask

    task automatic do_read(input logic [7:0] a, input logic [7:0] d,
                           input int rdy_delay, input logic cs_glitch);
        start_frame(1'b0);
        shift_mosi(a, 8);
        @(negedge clk);
        cs = 1'b1; mosi = 1'b0;
        if (cs_glitch) begin
            @(negedge clk); cs = 1'b0; mosi = 1'b1;
            @(negedge clk); cs = 1'b1; mosi = 1'b0;
        end
        repeat (rdy_delay - 1) @(negedge clk);
        @(negedge clk); ready = 1'b1;
        @(negedge clk); ready = 1'b0; miso = d[0];
        for (int i = 1; i < 8; i++) begin
            @(negedge clk); miso = d[i];
        end
        @(negedge clk); miso = 1'b0; op_done = 1'b1;
        @(negedge clk); op_done = 1'b0;
    endtask

    task automatic pop_one();
        @(negedge clk); rec_ready = 1'b1;
        @(negedge clk); rec_ready = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        apply_reset();
        total++; if (rec_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", rec_valid); end
        total++; if (rec_bus !== 18'h0) begin bad++; $display("FAIL reset_rec: got %h want 00000", rec_bus); end
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %b want 0", ovf); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (dbg_state !== 3'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
    endtask

    task automatic test_write();
        do_write(8'h03, 8'hA5, 1, 1'b0);
        total++; if (rec_valid !== 1'b1) begin bad++; $display("FAIL write_valid: got %b want 1", rec_valid); end
        total++; if (rec_bus !== {1'b0, 1'b1, 8'h03, 8'hA5}) begin bad++; $display("FAIL write_rec: got %h want %h", rec_bus, {1'b0, 1'b1, 8'h03, 8'hA5}); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL write_busy: got %b want 0", busy); end
        pop_one();
        total++; if (rec_valid !== 1'b0) begin bad++; $display("FAIL write_pop: got %b want 0", rec_valid); end
    endtask

    task automatic test_read();
        do_read(8'h1F, 8'h3C, 5, 1'b0);
        total++; if (rec_bus !== {1'b0, 1'b0, 8'h1F, 8'h3C} || rec_valid !== 1'b1) begin bad++; $display("FAIL read_rec: got v=%b %h want v=1 %h", rec_valid, rec_bus, {1'b0, 1'b0, 8'h1F, 8'h3C}); end
        pop_one();
        do_read(8'h02, 8'h81, 3, 1'b1);
        total++; if (rec_bus !== {1'b0, 1'b0, 8'h02, 8'h81} || rec_valid !== 1'b1) begin bad++; $display("FAIL read_cs_glitch: got v=%b %h want v=1 %h", rec_valid, rec_bus, {1'b0, 1'b0, 8'h02, 8'h81}); end
        pop_one();
    endtask

    task automatic test_frame_err();
        start_frame(1'b1);
        shift_mosi(8'h0D, 4);
        @(negedge clk); cs = 1'b1; mosi = 1'b0;
        @(negedge clk);
        total++; if (rec_bus !== {1'b1, 1'b1, 8'h0D, 8'h00} || rec_valid !== 1'b1) begin bad++; $display("FAIL frame_err_rec: got v=%b %h want v=1 %h", rec_valid, rec_bus, {1'b1, 1'b1, 8'h0D, 8'h00}); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL frame_err_busy: got %b want 0", busy); end
        pop_one();
        do_write(8'h07, 8'h5A, 0, 1'b0);
        total++; if (rec_bus !== {1'b0, 1'b1, 8'h07, 8'h5A}) begin bad++; $display("FAIL frame_err_next: got %h want %h", rec_bus, {1'b0, 1'b1, 8'h07, 8'h5A}); end
        pop_one();
    endtask

    task automatic test_addr_err();
        do_write(8'h20, 8'h11, 0, 1'b0);
        total++; if (rec_bus !== {1'b1, 1'b1, 8'h20, 8'h11}) begin bad++; $display("FAIL addr_err_rec: got %h want %h", rec_bus, {1'b1, 1'b1, 8'h20, 8'h11}); end
        pop_one();
    endtask

    task automatic test_idle_pulses();
        @(negedge clk); ready = 1'b1; op_done = 1'b1;
        @(negedge clk); ready = 1'b0; op_done = 1'b0;
        @(negedge clk);
        total++; if (rec_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL idle_pulses: got v=%b busy=%b want 0 0", rec_valid, busy); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 9; i++) do_write(8'(i), 8'(8'h10 + i), 0, 1'b0);
        total++; if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_set: got %b want 1", ovf); end
        rec_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            total++; if (rec_valid !== 1'b1 || rec_bus !== {1'b0, 1'b1, 8'(i), 8'(8'h10 + i)}) begin bad++; $display("FAIL ovf_drain%0d: got v=%b %h want v=1 %h", i, rec_valid, rec_bus, {1'b0, 1'b1, 8'(i), 8'(8'h10 + i)}); end
            @(negedge clk);
        end
        rec_ready = 1'b0;
        total++; if (rec_valid !== 1'b0) begin bad++; $display("FAIL ovf_drained: got %b want 0", rec_valid); end
        total++; if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %b want 1", ovf); end
        clr_ovf = 1'b1;
        @(negedge clk); clr_ovf = 1'b0;
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL ovf_clear: got %b want 0", ovf); end
    endtask

    task automatic test_full_push_pop();
        for (int i = 0; i < 8; i++) do_write(8'(i), 8'(8'h20 + i), 0, 1'b0);
        do_write(8'h08, 8'h28, 0, 1'b1);
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL full_pp_ovf: got %b want 0", ovf); end
        rec_ready = 1'b1;
        for (int i = 1; i < 9; i++) begin
            total++; if (rec_valid !== 1'b1 || rec_bus !== {1'b0, 1'b1, 8'(i), 8'(8'h20 + i)}) begin bad++; $display("FAIL full_pp_drain%0d: got v=%b %h want v=1 %h", i, rec_valid, rec_bus, {1'b0, 1'b1, 8'(i), 8'(8'h20 + i)}); end
            @(negedge clk);
        end
        rec_ready = 1'b0;
        total++; if (rec_valid !== 1'b0) begin bad++; $display("FAIL full_pp_count: got %b want 0", rec_valid); end
    endtask

    task automatic test_timeout();
        start_frame(1'b0);
        shift_mosi(8'h05, 8);
        @(negedge clk); cs = 1'b1; mosi = 1'b0;
        repeat (40) @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL wait_busy: got %b want 1", busy); end
        repeat (40) @(negedge clk);
`ifdef SPI_DEC_TIMEOUT_EN
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL timeout_busy: got %b want 0", busy); end
        total++; if (rec_bus !== {1'b1, 1'b0, 8'h05, 8'h00} || rec_valid !== 1'b1) begin bad++; $display("FAIL timeout_rec: got v=%b %h want v=1 %h", rec_valid, rec_bus, {1'b1, 1'b0, 8'h05, 8'h00}); end
        pop_one();
`else
        total++; if (busy !== 1'b1 || rec_valid !== 1'b0) begin bad++; $display("FAIL no_timeout: got busy=%b v=%b want 1 0", busy, rec_valid); end
        apply_reset();
`endif
    endtask

    task automatic test_reset_mid();
        do_write(8'h09, 8'h33, 0, 1'b0);
        total++; if (rec_valid !== 1'b1) begin bad++; $display("FAIL mid_pre_valid: got %b want 1", rec_valid); end
        start_frame(1'b1);
        shift_mosi(8'h04, 8);
        shift_mosi(8'hFF, 3);
        @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy: got %b want 1", busy); end
        apply_reset();
        total++; if (busy !== 1'b0 || rec_valid !== 1'b0 || ovf !== 1'b0) begin bad++; $display("FAIL mid_reset: got busy=%b v=%b ovf=%b want 0 0 0", busy, rec_valid, ovf); end
        total++; if (rec_bus !== 18'h0) begin bad++; $display("FAIL mid_reset_rec: got %h want 00000", rec_bus); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_write();
        test_read();
        test_frame_err();
        test_addr_err();
        test_idle_pulses();
        test_overflow();
        test_full_push_pop();
        test_timeout();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
